// File: rtl/aes_seq.sv
// aes_seq: sequencer between a block stream and an AES core.
// Handles key expansion (init) and block processing (next), and holds
// each result in a one-deep output register with valid/ready handshake.
// Optional feature macro: AES_KEY_CACHE_EN. When it is defined, a key strobe
// that matches the already-expanded key does not trigger re-expansion.
module aes_seq (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [127:0] key_i,
  input  logic         key_valid_i,
  input  logic [127:0] in_block_i,
  input  logic         encdec_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  output logic [127:0] out_block_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic         key_loaded_o,
  output logic         busy_o,
  output logic [31:0]  blk_cnt_o,
  output logic         core_init_o,
  output logic         core_next_o,
  output logic         core_encdec_o,
  output logic [127:0] core_key_o,
  output logic [127:0] core_block_o,
  input  logic         core_ready_i,
  input  logic         core_result_valid_i,
  input  logic [127:0] core_result_i
);

  typedef enum logic [2:0] {
    S_NOKEY, S_KINIT, S_KWAIT, S_IDLE, S_NEXT, S_BWAIT
  } state_t;

  state_t       state, state_nxt;
  logic [127:0] key_reg;
  logic         key_pend;
  logic         key_hit;
  logic         start_key;
  logic         accept;
  logic         load_out;

  // core_key_o always holds the last key handed to the core for expansion,
  // so it doubles as the cached key.
`ifdef AES_KEY_CACHE_EN
  assign key_hit = key_loaded_o && (key_i == core_key_o);
`else
  assign key_hit = 1'b0;
`endif

  // A matching strobe this cycle supersedes any older pending key, so it
  // also suppresses a key start that would otherwise begin now.
  assign start_key = key_pend && !(key_valid_i && key_hit) &&
                     ((state == S_NOKEY) || (state == S_IDLE));
  assign in_ready_o = (state == S_IDLE) && !key_pend && !key_valid_i;
  assign accept     = in_valid_i && in_ready_o;
  assign load_out   = (state == S_BWAIT) && core_ready_i && core_result_valid_i &&
                      (!out_valid_o || out_ready_i);

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_NOKEY;
    else       state <= state_nxt;
  end

  // Next-state decode and core strobes; key work always wins over blocks.
  always_comb begin
    state_nxt   = state;
    core_init_o = 1'b0;
    core_next_o = 1'b0;
    busy_o      = (state != S_IDLE);
    case (state)
      S_NOKEY: if (start_key) state_nxt = S_KINIT;
      S_KINIT: begin
        core_init_o = 1'b1;
        state_nxt   = S_KWAIT;
      end
      S_KWAIT: if (core_ready_i) state_nxt = S_IDLE;
      S_IDLE: begin
        if (start_key)   state_nxt = S_KINIT;
        else if (accept) state_nxt = S_NEXT;
      end
      S_NEXT: begin
        core_next_o = 1'b1;
        state_nxt   = S_BWAIT;
      end
      S_BWAIT: if (load_out) state_nxt = S_IDLE;
      default: state_nxt = S_NOKEY;
    endcase
  end

  // Key capture, pending flag and the expanded-key status.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      key_reg      <= '0;
      key_pend     <= 1'b0;
      key_loaded_o <= 1'b0;
      core_key_o   <= '0;
    end else begin
      if (key_valid_i) begin
        key_reg  <= key_i;
        key_pend <= !key_hit;
      end else if (start_key) begin
        key_pend <= 1'b0;
      end
      if (start_key) begin
        core_key_o   <= key_reg;
        key_loaded_o <= 1'b0;
      end else if (state == S_KWAIT && core_ready_i) begin
        key_loaded_o <= 1'b1;
      end
    end
  end

  // Block register to the core; held until the next accept.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      core_block_o  <= '0;
      core_encdec_o <= 1'b0;
    end else if (accept) begin
      core_block_o  <= in_block_i;
      core_encdec_o <= encdec_i;
    end
  end

  // Output register: loads a finished result, drains in any state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_block_o <= '0;
      out_valid_o <= 1'b0;
      blk_cnt_o   <= '0;
    end else if (load_out) begin
      out_block_o <= core_result_i;
      out_valid_o <= 1'b1;
      blk_cnt_o   <= blk_cnt_o + 32'd1;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_aes_seq.sv
// tb_aes_seq: randomized bench for aes_seq with a stand-in AES core.
// The stand-in core answers the FIPS-197 known-answer pair exactly and an
// invertible keyed mixing function otherwise, with random latency.
module tb_aes_seq;

  localparam logic [127:0] FK   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FP   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FC   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] MASK = 128'h5a5a_c3c3_0f0f_9696_a5a5_3c3c_f0f0_6969;
  localparam logic [127:0] KA   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KB   = 128'hfedcba98765432100123456789abcdef;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [127:0] key_i;
  logic         key_valid_i;
  logic [127:0] in_block_i;
  logic         encdec_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [127:0] out_block_o;
  logic         out_valid_o;
  logic         out_ready_i;
  logic         key_loaded_o;
  logic         busy_o;
  logic [31:0]  blk_cnt_o;
  logic         core_init_o;
  logic         core_next_o;
  logic         core_encdec_o;
  logic [127:0] core_key_o;
  logic [127:0] core_block_o;
  logic         c_rdy;
  logic         c_rv;
  logic [127:0] c_res;

  aes_seq dut (
    .clk_i(clk), .rst_i(rst_i), .key_i(key_i), .key_valid_i(key_valid_i),
    .in_block_i(in_block_i), .encdec_i(encdec_i), .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o), .out_block_o(out_block_o), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .key_loaded_o(key_loaded_o), .busy_o(busy_o),
    .blk_cnt_o(blk_cnt_o), .core_init_o(core_init_o), .core_next_o(core_next_o),
    .core_encdec_o(core_encdec_o), .core_key_o(core_key_o), .core_block_o(core_block_o),
    .core_ready_i(c_rdy), .core_result_valid_i(c_rv), .core_result_i(c_res)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int beats = 0;
  int init_cnt = 0;
  int both_cnt = 0;
  logic rnd_rdy = 1'b0;
  logic [127:0] cur_key = '0;
  logic [127:0] last_beat = '0;
  logic [127:0] exp_q[$];
  logic         prev_hold = 1'b0;
  logic [127:0] prev_blk = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Cipher stand-in: exact FIPS-197 answers for the known pair, otherwise
  // an invertible keyed swap so decrypt(encrypt(x)) == x.
  function automatic logic [127:0] cipher(input logic [127:0] k, input logic [127:0] b,
                                          input logic e);
    logic [127:0] t;
    if (k == FK && e && b == FP) return FC;
    if (k == FK && !e && b == FC) return FP;
    if (e) return {b[63:0], b[127:64]} ^ k ^ MASK;
    t = b ^ k ^ MASK;
    return {t[63:0], t[127:64]};
  endfunction

  // Stand-in AES core: ready drops on init/next, returns after 1..4 cycles.
  logic [127:0] c_key;
  logic [2:0]   c_cnt;
  logic         c_blk;
  always @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      c_rdy <= 1'b1; c_rv <= 1'b0; c_key <= '0; c_res <= '0; c_cnt <= '0; c_blk <= 1'b0;
    end else if (c_cnt != 0) begin
      c_cnt <= c_cnt - 3'd1;
      if (c_cnt == 3'd1) begin
        c_rdy <= 1'b1;
        c_rv  <= c_blk;
      end
    end else if (core_init_o) begin
      c_key <= core_key_o; c_rdy <= 1'b0; c_rv <= 1'b0; c_blk <= 1'b0;
      c_cnt <= 3'($urandom_range(1, 4));
    end else if (core_next_o) begin
      c_res <= cipher(c_key, core_block_o, core_encdec_o);
      c_rdy <= 1'b0; c_rv <= 1'b0; c_blk <= 1'b1;
      c_cnt <= 3'($urandom_range(1, 4));
    end
  end

  // Output monitor: in-order scoreboard, hold stability, strobe counters.
  always @(negedge clk) begin
    if (rst_i) begin
      prev_hold = 1'b0;
    end else begin
      if (core_init_o) init_cnt++;
      if (core_init_o && core_next_o) both_cnt++;
      if (prev_hold) begin
        chk("out_hold_v", 128'(out_valid_o), 128'd1);
        chk("out_hold_d", out_block_o, prev_blk);
      end
      if (out_valid_o && out_ready_i) begin
        beats++;
        last_beat = out_block_o;
        if (exp_q.size() == 0) chk("beat_unexpected", 128'd1, 128'd0);
        else chk("beat", out_block_o, exp_q.pop_front());
      end
      prev_hold = out_valid_o && !out_ready_i;
      prev_blk  = out_block_o;
    end
  end

  // Random output back-pressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy) out_ready_i = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe_key(input logic [127:0] k);
    key_i = k;
    key_valid_i = 1'b1;
    tick();
    key_valid_i = 1'b0;
    cur_key = k;
  endtask

  task automatic send_block(input logic [127:0] b, input logic e);
    bit got = 0;
    in_block_i = b;
    encdec_i = e;
    in_valid_i = 1'b1;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (in_ready_o) begin
        got = 1;
        exp_q.push_back(cipher(cur_key, b, e));
      end
      tick();
    end
    in_valid_i = 1'b0;
    if (!got) chk("accept_timeout", 128'd0, 128'd1);
  endtask

  task automatic wait_beats(input int target);
    for (int n = 0; n < 400 && beats < target; n++) tick();
    if (beats < target) chk("beat_timeout", 128'(beats), 128'(target));
  endtask

  task automatic wait_loaded_idle();
    int n = 0;
    while (!(key_loaded_o && !busy_o) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("key_load_timeout", 128'd0, 128'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"},   128'(in_ready_o),   128'd0);
    chk({tag, "_out_valid"},  128'(out_valid_o),  128'd0);
    chk({tag, "_key_loaded"}, 128'(key_loaded_o), 128'd0);
    chk({tag, "_init"},       128'(core_init_o),  128'd0);
    chk({tag, "_next"},       128'(core_next_o),  128'd0);
    chk({tag, "_busy"},       128'(busy_o),       128'd1);
    chk({tag, "_blk_cnt"},    128'(blk_cnt_o),    128'd0);
    chk({tag, "_out_block"},  out_block_o,        128'd0);
    chk({tag, "_core_key"},   core_key_o,         128'd0);
    chk({tag, "_core_block"}, core_block_o,       128'd0);
    chk({tag, "_encdec"},     128'(core_encdec_o), 128'd0);
  endtask

  initial begin
    int i0;
    int b0;
    logic seen;
    logic [127:0] rb;
    rst_i = 1'b1; key_i = '0; key_valid_i = 1'b0; in_block_i = '0;
    encdec_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    tick(); tick();
    @(negedge clk);
    check_reset_outputs("rst");
    tick();
    rst_i = 1'b0;

    // No key yet: an offered block must not be taken.
    in_block_i = FP; encdec_i = 1'b1; in_valid_i = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      seen |= in_ready_o;
      tick();
    end
    in_valid_i = 1'b0;
    chk("nokey_ready", 128'(seen), 128'd0);

    // First key: exactly one init pulse, then ready.
    i0 = init_cnt;
    strobe_key(FK);
    wait_loaded_idle();
    chk("init_pulses", 128'(init_cnt - i0), 128'd1);
    @(negedge clk);
    chk("ready_after_key", 128'(in_ready_o), 128'd1);
    tick();

    // FIPS-197 encrypt and decrypt.
    out_ready_i = 1'b1;
    send_block(FP, 1'b1);
    wait_beats(1);
    chk("fips_enc", last_beat, FC);
    chk("blk_cnt_1", 128'(blk_cnt_o), 128'd1);
    send_block(FC, 1'b0);
    wait_beats(2);
    chk("fips_dec", last_beat, FP);
    chk("blk_cnt_2", 128'(blk_cnt_o), 128'd2);

    // Back-pressure: two accepted, third blocked, then three in-order beats.
    out_ready_i = 1'b0;
    b0 = beats;
    send_block(128'h1111, 1'b1);
    send_block(128'h2222, 1'b0);
    in_block_i = 128'h3333; encdec_i = 1'b1; in_valid_i = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      seen |= in_ready_o;
      tick();
    end
    in_valid_i = 1'b0;
    chk("third_blocked", 128'(seen), 128'd0);
    chk("stall_busy", 128'(busy_o), 128'd1);
    chk("stall_valid", 128'(out_valid_o), 128'd1);
    chk("stall_no_beat", 128'(beats - b0), 128'd0);
    out_ready_i = 1'b1;
    wait_beats(b0 + 2);
    send_block(128'h3333, 1'b1);
    wait_beats(b0 + 3);

    // Key change while a block waits on the core.
    b0 = beats;
    rb = 128'hdead_beef_0123_4567_89ab_cdef_0f1e_2d3c;
    send_block(rb, 1'b1);
    tick();
    strobe_key(KA);
    wait_beats(b0 + 1);
    chk("old_key_beat", last_beat, cipher(FK, rb, 1'b1));
    send_block(rb, 1'b1);
    wait_beats(b0 + 2);
    chk("new_key_beat", last_beat, cipher(KA, rb, 1'b1));

    // Random traffic with random back-pressure and occasional key changes.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) strobe_key($urandom_range(0, 1) ? KA : KB);
      rb = {$urandom, $urandom, $urandom, $urandom};
      send_block(rb, 1'($urandom_range(0, 1)));
    end
    rnd_rdy = 1'b0;
    tick();
    out_ready_i = 1'b1;
    for (int n = 0; n < 400 && exp_q.size() != 0; n++) tick();
    chk("random_drained", 128'(exp_q.size()), 128'd0);

    // Re-strobe of the key that is already expanded.
    wait_loaded_idle();
    i0 = init_cnt;
    strobe_key(cur_key);
    for (int n = 0; n < 15; n++) tick();
    wait_loaded_idle();
`ifdef AES_KEY_CACHE_EN
    chk("same_key_init", 128'(init_cnt - i0), 128'd0);
`else
    chk("same_key_init", 128'(init_cnt - i0), 128'd1);
`endif

    // Reset in the middle of a block: no beat, key discarded.
    b0 = beats;
    send_block(128'hcafe, 1'b1);
    tick();
    rst_i = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    exp_q.delete();
    tick(); tick();
    rst_i = 1'b0;
    for (int n = 0; n < 10; n++) tick();
    @(negedge clk);
    chk("midrst_no_beat", 128'(beats - b0), 128'd0);
    chk("midrst_no_key", 128'(key_loaded_o), 128'd0);
    chk("midrst_not_ready", 128'(in_ready_o), 128'd0);
    chk("init_next_excl", 128'(both_cnt), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
